// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback mux, architectural register file and retire counter
//
// Purpose: selects the writeback data and destination from the MEM/WB outputs,
// commits the result on the clock edge, serves two combinational read ports to ID,
// exports the final writeback data/reg/enable for EX forwarding and counts retired writes.
//
// Optional feature macro: WB_BYPASS_EN (write-through from the writeback bus to the read ports).
//
// Ports:
//   Clk          in   1       system clock, all state updates on posedge
//   Rst          in   1       synchronous active-high reset
//   RegWrite     in   1       write enable from MEM/WB
//   JalSel       in   1       1: destination = LINK_REG, WriteRegIn ignored
//   MemToReg     in   2       00 ALUResult, 01 MemReadData, 10 LinkAddr, 11 ALUResult
//   ALUResult    in   DATA_W  ALU result
//   MemReadData  in   DATA_W  data-memory read data
//   LinkAddr     in   DATA_W  return address (PC+8)
//   WriteRegIn   in   ADDR_W  destination index
//   ReadReg1/2   in   ADDR_W  ID-stage read indices
//   ReadData1/2  out  DATA_W  read port data (combinational)
//   WBData       out  DATA_W  selected writeback data
//   WBReg        out  ADDR_W  effective destination index
//   WBEnable     out  1       RegWrite && WBReg != 0
//   RetireCount  out  32      committed register writes (wraps silently)

module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int LINK_REG = 31
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              RegWrite,
    input  logic              JalSel,
    input  logic [1:0]        MemToReg,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] MemReadData,
    input  logic [DATA_W-1:0] LinkAddr,
    input  logic [ADDR_W-1:0] WriteRegIn,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] WBData,
    output logic [ADDR_W-1:0] WBReg,
    output logic              WBEnable,
    output logic [31:0]       RetireCount
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Writeback selection; the reserved encoding falls back to the ALU result.
    always_comb begin
        WBData = ALUResult;
        case (MemToReg)
            2'b01:   WBData = MemReadData;
            2'b10:   WBData = LinkAddr;
            default: WBData = ALUResult;
        endcase
        WBReg    = JalSel ? ADDR_W'(LINK_REG) : WriteRegIn;
        // RegWrite gates first so garbage on the other inputs cannot enable a write.
        WBEnable = RegWrite && (WBReg != '0);
    end

    // Commit and retire counting; reset wins over any write on the same edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            RetireCount <= 32'd0;
        end else if (WBEnable) begin
            regs[WBReg] <= WBData;
            RetireCount <= RetireCount + 32'd1;
        end
    end

    // Read ports: register 0 is hardwired to zero regardless of storage contents.
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (ReadReg1 != '0) begin
            ReadData1 = regs[ReadReg1];
`ifdef WB_BYPASS_EN
            if (WBEnable && (ReadReg1 == WBReg)) begin
                ReadData1 = WBData;
            end
`endif
        end
        if (ReadReg2 != '0) begin
            ReadData2 = regs[ReadReg2];
`ifdef WB_BYPASS_EN
            if (WBEnable && (ReadReg2 == WBReg)) begin
                ReadData2 = WBData;
            end
`endif
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile with a behavioural model

module tb_wb_regfile;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        RegWrite = 1'b0;
    logic        JalSel = 1'b0;
    logic [1:0]  MemToReg = 2'b00;
    logic [31:0] ALUResult = '0;
    logic [31:0] MemReadData = '0;
    logic [31:0] LinkAddr = '0;
    logic [4:0]  WriteRegIn = '0;
    logic [4:0]  ReadReg1 = '0;
    logic [4:0]  ReadReg2 = '0;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] WBData;
    logic [4:0]  WBReg;
    logic        WBEnable;
    logic [31:0] RetireCount;

    wb_regfile dut (
        .Clk(Clk), .Rst(Rst), .RegWrite(RegWrite), .JalSel(JalSel),
        .MemToReg(MemToReg), .ALUResult(ALUResult), .MemReadData(MemReadData),
        .LinkAddr(LinkAddr), .WriteRegIn(WriteRegIn), .ReadReg1(ReadReg1),
        .ReadReg2(ReadReg2), .ReadData1(ReadData1), .ReadData2(ReadData2),
        .WBData(WBData), .WBReg(WBReg), .WBEnable(WBEnable), .RetireCount(RetireCount)
    );

    always #5 Clk = ~Clk;

    int passed = 0;
    int total  = 0;
    bit cmp_en = 1'b0;

    // Architectural state as the specification describes it.
    logic [31:0] model_regs [32];
    logic [31:0] model_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] exp_wbdata();
        case (MemToReg)
            2'd1:    return MemReadData;
            2'd2:    return LinkAddr;
            default: return ALUResult;
        endcase
    endfunction

    function automatic logic [4:0] exp_wbreg();
        return JalSel ? 5'd31 : WriteRegIn;
    endfunction

    function automatic logic exp_wben();
        return RegWrite && (exp_wbreg() != 5'd0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (exp_wben() && idx == exp_wbreg()) return exp_wbdata();
`endif
        return model_regs[idx];
    endfunction

    always @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
            model_cnt = 32'd0;
        end else if (exp_wben()) begin
            model_regs[exp_wbreg()] = exp_wbdata();
            model_cnt = model_cnt + 32'd1;
        end
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            check("cyc_rd1",    ReadData1,           exp_read(ReadReg1));
            check("cyc_rd2",    ReadData2,           exp_read(ReadReg2));
            check("cyc_wbdata", WBData,              exp_wbdata());
            check("cyc_wbreg",  {27'd0, WBReg},      {27'd0, exp_wbreg()});
            check("cyc_wben",   {31'd0, WBEnable},   {31'd0, exp_wben()});
            check("cyc_count",  RetireCount,         model_cnt);
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // Reset and full read sweep.
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i);
            ReadReg2 = 5'(31 - i);
            #1;
            check("reset_rd1", ReadData1, 32'd0);
            check("reset_rd2", ReadData2, 32'd0);
        end
        check("reset_count", RetireCount, 32'd0);
        step();
        cmp_en = 1'b1;

        // ALU write to reg 8.
        RegWrite = 1'b1; MemToReg = 2'b00; WriteRegIn = 5'd8; ALUResult = 32'h0000_1234;
        step();
        RegWrite = 1'b0; ReadReg1 = 5'd8;
        #1;
        check("alu_rd", ReadData1, 32'h0000_1234);
        check("alu_count", RetireCount, 32'd1);

        // JAL forces reg 31.
        RegWrite = 1'b1; JalSel = 1'b1; MemToReg = 2'b10; LinkAddr = 32'h0040_0010; WriteRegIn = 5'd5;
        #1;
        check("jal_wbreg", {27'd0, WBReg}, 32'd31);
        check("jal_wbdata", WBData, 32'h0040_0010);
        step();
        RegWrite = 1'b0; ReadReg1 = 5'd31; ReadReg2 = 5'd5;
        #1;
        check("jal_rd31", ReadData1, 32'h0040_0010);
        check("jal_rd5", ReadData2, 32'd0);
        check("jal_wbreg_nowrite", {27'd0, WBReg}, 32'd31);
        check("jal_wben_nowrite", {31'd0, WBEnable}, 32'd0);
        check("jal_count", RetireCount, 32'd2);
        JalSel = 1'b0;

        // Register 0 guard.
        RegWrite = 1'b1; MemToReg = 2'b00; WriteRegIn = 5'd0; ALUResult = 32'hFFFF_FFFF; ReadReg1 = 5'd0;
        #1;
        check("r0_wben", {31'd0, WBEnable}, 32'd0);
        step();
        RegWrite = 1'b0;
        #1;
        check("r0_rd", ReadData1, 32'd0);
        check("r0_count", RetireCount, 32'd2);

        // Same-cycle read of reg 9.
        RegWrite = 1'b1; WriteRegIn = 5'd9; ALUResult = 32'h0000_0001;
        step();
        ALUResult = 32'hDEAD_BEEF; ReadReg1 = 5'd9;
        #1;
`ifdef WB_BYPASS_EN
        check("same_cycle_rd", ReadData1, 32'hDEAD_BEEF);
`else
        check("same_cycle_rd", ReadData1, 32'h0000_0001);
`endif
        step();
        RegWrite = 1'b0;
        #1;
        check("next_cycle_rd", ReadData1, 32'hDEAD_BEEF);
        check("r9_count", RetireCount, 32'd4);

        // Reset coinciding with a write to reg 10.
        Rst = 1'b1; RegWrite = 1'b1; MemToReg = 2'b01; MemReadData = 32'hA5A5_A5A5; WriteRegIn = 5'd10;
        step();
        Rst = 1'b0; RegWrite = 1'b0; ReadReg1 = 5'd10;
        #1;
        check("rst_write_rd", ReadData1, 32'd0);
        check("rst_write_count", RetireCount, 32'd0);

        // Randomized traffic, checked every cycle against the model.
        for (int n = 0; n < 3000; n++) begin
            Rst         = ($urandom_range(0, 99) == 0);
            RegWrite    = ($urandom_range(0, 3) != 0);
            JalSel      = ($urandom_range(0, 7) == 0);
            MemToReg    = 2'($urandom_range(0, 3));
            ALUResult   = $urandom;
            MemReadData = $urandom;
            LinkAddr    = $urandom;
            WriteRegIn  = 5'($urandom_range(0, 31));
            // Bias reads toward the current destination to exercise write/read overlap.
            ReadReg1    = ($urandom_range(0, 3) == 0) ? WriteRegIn : 5'($urandom_range(0, 31));
            ReadReg2    = 5'($urandom_range(0, 31));
            step();
        end

        Rst = 1'b0; RegWrite = 1'b0;
        step();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
